// File: rtl/mod12_down_timer_pkg.sv
// mod12_down_timer_pkg
// Shared definitions for the mod-12 down timer:
//   state_t   : timer control states (IDLE, RUN, HOLD, DONE)
//   MOD12_MAX : largest count value of a modulo-12 digit (wrap target)
package mod12_down_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [3:0] MOD12_MAX = 4'd11;

endpackage

// File: rtl/mod12_dec_cell.sv
// mod12_dec_cell
// Pure combinational decrement-with-wrap for one modulo-MODULUS digit.
// Suitable for cascading: borrow_next of one digit can drive en of the next.
// Ports:
//   q           in  WIDTH  current digit value
//   en          in  1      decrement request
//   q_next      out WIDTH  value after the (optional) decrement
//   borrow_next out 1      high when a decrement passes through 0
module mod12_dec_cell #(
  parameter int MODULUS = 12,
  parameter int WIDTH   = 4
) (
  input  logic [WIDTH-1:0] q,
  input  logic             en,
  output logic [WIDTH-1:0] q_next,
  output logic             borrow_next
);

  // Wrap target is MODULUS-1, never the all-ones value of the register.
  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);

  always_comb begin
    q_next      = q;
    borrow_next = 1'b0;
    if (en) begin
      if (q == '0) begin
        q_next      = MAX_Q;
        borrow_next = 1'b1;
      end else begin
        q_next = q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/mod12_down_timer.sv
// mod12_down_timer
// Presettable modulo-MODULUS down counter with run/pause/stop control.
// A run ends in DONE after WRAPS passes through zero; the final pass leaves
// q at 0 instead of wrapping.
// Ports:
//   clk      in  1      rising-edge clock
//   rst_n    in  1      synchronous active-low reset
//   load     in  1      preset request (IDLE/DONE only)
//   load_val in  WIDTH  preset value, clamped to MODULUS-1
//   start    in  1      begin counting (IDLE/DONE only)
//   pause    in  1      hold count while high
//   stop     in  1      abort RUN/HOLD to IDLE
//   q        out WIDTH  current count
//   borrow   out 1      one-cycle pulse on each 0 -> next transition
//   done     out 1      high in DONE
//   busy     out 1      high in RUN or HOLD
//   load_err out 1      one-cycle pulse when load_val was clamped
module mod12_down_timer
  import mod12_down_timer_pkg::*;
#(
  parameter int MODULUS = 12,
  parameter int WIDTH   = 4,
  parameter int WRAPS   = 2,
  parameter int WCNT_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             pause,
  input  logic             stop,
  output logic [WIDTH-1:0] q,
  output logic             borrow,
  output logic             done,
  output logic             busy,
  output logic             load_err
);

  localparam logic [WIDTH-1:0]  MAX_Q     = WIDTH'(MODULUS - 1);
  localparam logic [WCNT_W-1:0] LAST_WRAP = WCNT_W'(WRAPS - 1);

  state_t             state_reg;
  logic [WIDTH-1:0]   q_reg;
  logic [WCNT_W-1:0]  wcnt_reg;
  logic               borrow_reg;
  logic               done_reg;
  logic               busy_reg;
  logic               load_err_reg;

  logic [WIDTH-1:0]   dec_q;
  logic               dec_borrow;
  logic               dec_en;
  logic               load_over;
  logic [WIDTH-1:0]   load_q;

  // Decrement only when RUN is not pre-empted by stop or pause.
  assign dec_en    = (state_reg == RUN) && !stop && !pause;
  assign load_over = (load_val > MAX_Q);
  assign load_q    = load_over ? MAX_Q : load_val;

  mod12_dec_cell #(
    .MODULUS (MODULUS),
    .WIDTH   (WIDTH)
  ) u_dec (
    .q           (q_reg),
    .en          (dec_en),
    .q_next      (dec_q),
    .borrow_next (dec_borrow)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      q_reg        <= '0;
      wcnt_reg     <= '0;
      borrow_reg   <= 1'b0;
      done_reg     <= 1'b0;
      busy_reg     <= 1'b0;
      load_err_reg <= 1'b0;
    end else begin
      // Pulse outputs default low; they are re-raised only by their trigger.
      borrow_reg   <= 1'b0;
      load_err_reg <= 1'b0;
      case (state_reg)
        IDLE, DONE: begin
          if (load) begin
            q_reg        <= load_q;
            load_err_reg <= load_over;
            wcnt_reg     <= '0;
            state_reg    <= start ? RUN : IDLE;
            busy_reg     <= start;
            done_reg     <= 1'b0;
          end else if (start) begin
            // Restart from the current q; no decrement on this edge.
            wcnt_reg  <= '0;
            state_reg <= RUN;
            busy_reg  <= 1'b1;
            done_reg  <= 1'b0;
          end
        end
        RUN: begin
          if (stop) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else if (pause) begin
            state_reg <= HOLD;
          end else if (dec_borrow && (wcnt_reg == LAST_WRAP)) begin
            // Final pass through zero: q stays 0 rather than wrapping.
            borrow_reg <= 1'b1;
            state_reg  <= DONE;
            done_reg   <= 1'b1;
            busy_reg   <= 1'b0;
          end else begin
            q_reg      <= dec_q;
            borrow_reg <= dec_borrow;
            if (dec_borrow) begin
              wcnt_reg <= wcnt_reg + 1'b1;
            end
          end
        end
        HOLD: begin
          if (stop) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else if (!pause) begin
            // Resume edge: back to RUN without decrementing.
            state_reg <= RUN;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign q        = q_reg;
  assign borrow   = borrow_reg;
  assign done     = done_reg;
  assign busy     = busy_reg;
  assign load_err = load_err_reg;

endmodule

// File: tb/tb_mod12_down_timer.sv
// tb_mod12_down_timer
// Self-checking bench. The reference model tracks the total number of
// decrements remaining in the run ("rem"): q is rem mod 12, a borrow occurs
// whenever a decrement is taken while rem is a multiple of 12, and the run
// finishes when a decrement is requested with rem already at 0.
module tb_mod12_down_timer;
  import mod12_down_timer_pkg::*;

  localparam int MOD   = int'(MOD12_MAX) + 1;
  localparam int WRAPS = 2;
  localparam int BASE  = (WRAPS - 1) * MOD;

  logic       clk = 1'b0;
  logic       rst_n, load, start, pause, stop;
  logic [3:0] load_val;
  logic [3:0] q;
  logic       borrow, done, busy, load_err;

  int total = 0;
  int bad   = 0;
  int nstep = 0;

  // Reference model state
  int rem;
  bit running, paused, finished;
  bit m_borrow, m_lerr;

  always #5 clk = ~clk;

  mod12_down_timer #(
    .MODULUS (12),
    .WIDTH   (4),
    .WRAPS   (WRAPS),
    .WCNT_W  (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (load_val),
    .start    (start),
    .pause    (pause),
    .stop     (stop),
    .q        (q),
    .borrow   (borrow),
    .done     (done),
    .busy     (busy),
    .load_err (load_err)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Apply the specification's rules to the inputs seen at this edge.
  task automatic model_edge();
    int lv;
    m_borrow = 1'b0;
    m_lerr   = 1'b0;
    if (!rst_n) begin
      rem = BASE; running = 0; paused = 0; finished = 0;
    end else if (!running) begin
      if (load) begin
        lv       = (int'(load_val) > MOD - 1) ? MOD - 1 : int'(load_val);
        m_lerr   = (int'(load_val) > MOD - 1);
        rem      = lv + BASE;
        finished = 0;
      end
      if (start) begin
        if (!load) rem = (rem % MOD) + BASE;
        running = 1; paused = 0; finished = 0;
      end
    end else if (stop) begin
      running = 0; paused = 0;
    end else if (paused) begin
      if (!pause) paused = 0;
    end else if (pause) begin
      paused = 1;
    end else begin
      if (rem % MOD == 0) m_borrow = 1'b1;
      if (rem == 0) begin
        running = 0; finished = 1;
      end else begin
        rem--;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    nstep++;
    chk("q", 8'(q), 8'(rem % MOD));
    chk("borrow", 8'(borrow), 8'(m_borrow));
    chk("done", 8'(done), 8'(finished));
    chk("busy", 8'(busy), 8'(running));
    chk("load_err", 8'(load_err), 8'(m_lerr));
    $display("step %0d rst_n=%b load=%b lv=%0d start=%b pause=%b stop=%b -> q=%0d borrow=%b done=%b busy=%b load_err=%b",
             nstep, rst_n, load, load_val, start, pause, stop, q, borrow, done, busy, load_err);
  endtask

  task automatic idle_inputs();
    load = 0; load_val = 0; start = 0; pause = 0; stop = 0;
  endtask

  initial begin
    int n;
    rem = BASE; running = 0; paused = 0; finished = 0;
    rst_n = 0;
    idle_inputs();
    @(negedge clk);

    // 1. Reset then idle
    step(); step();
    rst_n = 1;
    step(); step(); step();
    chk("idle_q", 8'(q), 8'd0);
    chk("idle_busy", 8'(busy), 8'd0);

    // 2. Full run from 3, latency to done
    load = 1; load_val = 4'd3; step();
    load = 0; start = 1; step();
    start = 0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      n++;
      if (done) break;
    end
    chk("latency", 8'(n), 8'(3 + (WRAPS - 1) * MOD + 1));
    chk("done_q", 8'(q), 8'd0);

    // 3. Clamp
    load = 1; load_val = 4'd14; step();
    chk("clamp_q", 8'(q), 8'd11);
    chk("clamp_err", 8'(load_err), 8'd1);
    load = 0; step();
    chk("clamp_err_pulse", 8'(load_err), 8'd0);
    load = 1; load_val = 4'd11; step();
    chk("max_no_err", 8'(load_err), 8'd0);

    // 4. Pause / resume at q=7
    load_val = 4'd9; start = 1; step();
    load = 0; start = 0;
    step(); step();
    pause = 1;
    repeat (5) step();
    chk("hold_q", 8'(q), 8'd7);
    pause = 0; step();
    chk("resume_q", 8'(q), 8'd7);
    step();
    chk("after_resume_q", 8'(q), 8'd6);

    // 5. Load ignored in RUN, then stop at q=4
    step();
    load = 1; load_val = 4'd2; step();
    chk("ignored_load_q", 8'(q), 8'd4);
    load = 0; stop = 1; step();
    stop = 0;
    chk("stop_q", 8'(q), 8'd4);
    chk("stop_busy", 8'(busy), 8'd0);

    // 6. Reset mid-run, then simultaneous load+start
    load = 1; load_val = 4'd11; start = 1; step();
    load = 0; start = 0;
    step(); step();
    rst_n = 0; step();
    chk("rst_mid_q", 8'(q), 8'd0);
    rst_n = 1; load = 1; load_val = 4'd1; start = 1; step();
    chk("ld_st_q", 8'(q), 8'd1);
    chk("ld_st_busy", 8'(busy), 8'd1);
    load = 0; start = 0;
    step(); step();
    chk("wrap_q", 8'(q), 8'd11);
    chk("wrap_borrow", 8'(borrow), 8'd1);

    // Randomized phase against the model
    for (int i = 0; i < 600; i++) begin
      rst_n    = ($urandom_range(0, 99) != 0);
      load     = ($urandom_range(0, 9) == 0);
      load_val = 4'($urandom_range(0, 15));
      start    = ($urandom_range(0, 7) == 0);
      pause    = ($urandom_range(0, 5) == 0);
      stop     = ($urandom_range(0, 24) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mod12_down_timer.md
Name: mod12_down_timer

Overview:
- Presettable modulo-12 down counter with run/pause/stop control and a terminal-count state machine.
- Complements the team's free-running mod-12 up counter. Used as a countdown timer or as the borrow-chained low digit of a larger down-count.
- Counts down from a loaded value, wraps 0 -> 11 with a borrow pulse, and stops in DONE after a programmed number of wraps.

Parameters:
- MODULUS, 12, count range 0..MODULUS-1.
- WIDTH, 4, counter width; must satisfy 2**WIDTH >= MODULUS.
- WRAPS, 2, number of 0 -> wrap events that end a run (>=1).
- WCNT_W, 4, width of the internal wrap counter; must hold WRAPS-1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- load  in  1  load request; honoured only in IDLE or DONE.
- load_val  in  WIDTH  preset value.
- start  in  1  begin counting; honoured only in IDLE or DONE.
- pause  in  1  level; hold count while high.
- stop  in  1  abort to IDLE from RUN/HOLD.
- q  out  WIDTH  current count.
- borrow  out  1  one-cycle pulse on every 0 -> next transition.
- done  out  1  level; high in DONE.
- busy  out  1  level; high in RUN or HOLD.
- load_err  out  1  one-cycle pulse when a load value was clamped.

Behaviour:
- Reset (rst_n low at an edge): q=0, state=IDLE, wrap count=0, borrow=0, done=0, busy=0, load_err=0. Reset takes priority over all inputs, including mid-run.
- All outputs are registered. Every input is sampled on the rising edge.
- States are IDLE, RUN, HOLD and DONE. done = (state==DONE); busy = (state==RUN || state==HOLD).
- Load (IDLE/DONE only):
  - q <= load_val if load_val < MODULUS; otherwise q <= MODULUS-1 and load_err pulses.
  - Wrap count <= 0. A DONE state moves to IDLE, which clears done.
- Start (IDLE/DONE only): state <= RUN and wrap count <= 0. No decrement happens on the start edge.
  - If start and load arrive on the same edge, the load value is applied and the state goes to RUN.
  - Start alone from DONE restarts from the current q, which is 0.
- load and start are ignored in RUN and HOLD.
- RUN, on each edge, in priority order:
  - stop: go to IDLE, q holds.
  - pause: go to HOLD, q holds.
  - Otherwise decrement:
    - q != 0: q <= q-1.
    - q == 0 and wrap count < WRAPS-1: q <= MODULUS-1, borrow pulses, wrap count increments.
    - q == 0 and wrap count == WRAPS-1: q stays 0, borrow pulses, state goes to DONE, done rises.
- HOLD: stop goes to IDLE. If pause is low, return to RUN; no decrement on the resume edge. Otherwise hold.
- DONE: q and done hold until load or start.
- borrow and load_err are never high for two consecutive cycles unless their trigger repeats.
- Width rule: arithmetic stays in WIDTH bits. The wrap value is MODULUS-1, never 2**WIDTH-1.
- Latency rule: with load value L and no pause, done rises L + (WRAPS-1)*MODULUS + 1 edges after the start edge.

Decomposition:
- Shared package holds:
  - the state enum: IDLE, RUN, HOLD, DONE;
  - the constant MOD12_MAX = 4'd11.
- One natural sub-module, mod12_dec_cell: a pure combinational decrement-with-wrap.
  - Inputs: q, en. Outputs: q_next, borrow_next.
  - Reusable for cascaded digits.
- The FSM stays in the top module.

Test Plan:
1. Reset then idle: hold rst_n=0 for 2 edges, then release with no other stimulus -> q=0, done=0, busy=0, borrow=0 indefinitely.
2. Full run: load=1, load_val=3 at edge 0; start at edge 1.
   - q runs 3,2,1,0,11,10,...,0.
   - borrow pulses at edges 5 and 17.
   - done rises at edge 17 (3+12+1 edges after start) with q=0. busy drops on the same edge.
3. Clamp: load_val=14 in IDLE -> q=11 and load_err high for exactly one cycle. load_val=11 -> q=11 with no load_err.
4. Pause/resume: pause high for 5 cycles while q=7 -> q holds 7 and the state is HOLD. On release, the first edge leaves q=7 (resume edge) and the next edge gives q=6.
5. Stop and ignored load: mid-run at q=5, assert load with load_val=2 -> q keeps decrementing. Then assert stop at q=4 -> IDLE with q=4, busy=0, done=0.
6. Reset mid-run and simultaneous load+start:
   - rst_n low at q=9 -> all outputs at reset values on that edge.
   - Then load_val=1 with start on the same edge -> q=1 and busy=1. Next edges give q=0, then 11 with a borrow pulse.
